// File: rtl/riscv_pkg.sv
// Shared frontend types and helpers: branch prediction record, counter constants
// and the saturating-counter update used by the gshare predictor.
package riscv_pkg;

  localparam int XLEN      = 32;
  localparam int GHR_MAX   = 16;
  localparam int CTR_W_MAX = 3;

  // Weakly not-taken for the default 2-bit counters.
  localparam logic [1:0] CTR_WEAK_NT = 2'b01;

  typedef struct packed {
    logic               valid;
    logic               taken;
    logic [XLEN-1:0]    target;
    logic [GHR_MAX-1:0] ghr;
  } branch_pred_t;

  function automatic logic [CTR_W_MAX-1:0] sat_update(
    input logic [CTR_W_MAX-1:0] ctr,
    input logic                 taken,
    input logic [CTR_W_MAX-1:0] ctr_max
  );
    logic [CTR_W_MAX-1:0] nxt;
    if (taken) begin
      nxt = (ctr == ctr_max) ? ctr : ctr + CTR_W_MAX'(1);
    end else begin
      nxt = (ctr == {CTR_W_MAX{1'b0}}) ? ctr : ctr - CTR_W_MAX'(1);
    end
    return nxt;
  endfunction

endpackage

// File: rtl/gshare_predictor_pht_bank.sv
// Pattern history table: flop array of saturating counters with one combinational
// read port and one training write port; no read/write bypass.
module pht_bank
  import riscv_pkg::*;
#(
  parameter int ENTRIES  = 256,
  parameter int CTR_BITS = 2,
  parameter int IW       = $clog2(ENTRIES)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [IW-1:0]       rd_idx,
  output logic [CTR_BITS-1:0] rd_ctr,
  input  logic                wr_en,
  input  logic [IW-1:0]       wr_idx,
  input  logic                wr_taken
);

  localparam logic [CTR_BITS-1:0] INIT_VAL = CTR_BITS'((1 << (CTR_BITS - 1)) - 1);
  localparam logic [CTR_BITS-1:0] CTR_MAX  = {CTR_BITS{1'b1}};

  logic [CTR_BITS-1:0] ctr_r [ENTRIES];

  assign rd_ctr = ctr_r[rd_idx];

  // Counter array: async init to weakly not-taken, saturating train on write.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < ENTRIES; i++) begin
        ctr_r[i] <= INIT_VAL;
      end
    end else if (wr_en) begin
      ctr_r[wr_idx] <= CTR_BITS'(sat_update(CTR_W_MAX'(ctr_r[wr_idx]), wr_taken,
                                            CTR_W_MAX'(CTR_MAX)));
    end
  end

endmodule

// File: rtl/gshare_predictor.sv
// Gshare direction predictor with BTB/RAS target selection and speculative GHR.
// Optional PRED_STATS_EN adds saturating branch/mispredict statistics outputs.
module gshare_predictor
  import riscv_pkg::*;
#(
  parameter int PHT_ENTRIES = 256,
  parameter int GHR_BITS    = 8,
  parameter int CTR_BITS    = 2,
  parameter int XLEN        = riscv_pkg::XLEN
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                predict_en,
  input  logic [XLEN-1:0]     pc,
  input  logic                btb_hit,
  input  logic [XLEN-1:0]     btb_target,
  input  logic                btb_is_return,
  input  logic                ras_valid,
  input  logic [XLEN-1:0]     ras_target,
  input  logic                update_en,
  input  logic [XLEN-1:0]     update_pc,
  input  logic                update_is_branch,
  input  logic                update_taken,
  input  logic [XLEN-1:0]     update_target,
  input  logic [GHR_BITS-1:0] update_ghr,
  input  logic                update_mispredict,
  output branch_pred_t        prediction_out
`ifdef PRED_STATS_EN
  ,
  output logic [31:0]         stat_branches,
  output logic [31:0]         stat_mispredicts
`endif
);

  localparam int IW = $clog2(PHT_ENTRIES);

  logic [GHR_BITS-1:0] ghr_r;
  logic [IW-1:0]       pred_idx_s;
  logic [IW-1:0]       upd_idx_s;
  logic [CTR_BITS-1:0] pred_ctr_s;
  logic                pred_valid_s;
  logic                pred_taken_s;
  logic [XLEN-1:0]     pred_target_s;
  logic                train_s;
  logic                recover_s;
  branch_pred_t        pred_s;
  logic                unused_s;

  assign pred_idx_s   = pc[IW+1:2] ^ IW'(ghr_r);
  assign upd_idx_s    = update_pc[IW+1:2] ^ IW'(update_ghr);
  assign pred_valid_s = predict_en & btb_hit;
  assign train_s      = update_en & update_is_branch;
  assign recover_s    = update_en & update_mispredict;

  pht_bank #(
    .ENTRIES  (PHT_ENTRIES),
    .CTR_BITS (CTR_BITS),
    .IW       (IW)
  ) u_pht (
    .clk      (clk),
    .reset    (reset),
    .rd_idx   (pred_idx_s),
    .rd_ctr   (pred_ctr_s),
    .wr_en    (train_s),
    .wr_idx   (upd_idx_s),
    .wr_taken (update_taken)
  );

  // Direction/target selection: a valid RAS return overrides the counter.
  always_comb begin
    pred_taken_s  = 1'b0;
    pred_target_s = pc + {{(XLEN-3){1'b0}}, 3'd4};
    if (btb_is_return && ras_valid) begin
      pred_taken_s  = 1'b1;
      pred_target_s = ras_target;
    end else if (pred_ctr_s[CTR_BITS-1]) begin
      pred_taken_s  = 1'b1;
      pred_target_s = btb_target;
    end else begin
      pred_taken_s  = 1'b0;
    end
  end

  // Output record is all-zero whenever no prediction is being made.
  always_comb begin
    pred_s = {$bits(branch_pred_t){1'b0}};
    if (pred_valid_s) begin
      pred_s.valid  = 1'b1;
      pred_s.taken  = pred_taken_s;
      pred_s.target = pred_target_s;
      pred_s.ghr    = GHR_MAX'(ghr_r);
    end else begin
      pred_s = {$bits(branch_pred_t){1'b0}};
    end
  end

  assign prediction_out = pred_s;

  // Global history: EX recovery takes priority over the speculative shift.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ghr_r <= {GHR_BITS{1'b0}};
    end else if (recover_s) begin
      ghr_r <= {update_ghr[GHR_BITS-2:0], update_taken};
    end else if (pred_valid_s) begin
      ghr_r <= {ghr_r[GHR_BITS-2:0], pred_taken_s};
    end
  end

`ifdef PRED_STATS_EN
  logic [31:0] stat_br_r;
  logic [31:0] stat_mp_r;

  // Saturating statistics of trained branches and their mispredictions.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stat_br_r <= 32'd0;
      stat_mp_r <= 32'd0;
    end else begin
      if (train_s && (stat_br_r != 32'hFFFF_FFFF)) begin
        stat_br_r <= stat_br_r + 32'd1;
      end
      if (train_s && update_mispredict && (stat_mp_r != 32'hFFFF_FFFF)) begin
        stat_mp_r <= stat_mp_r + 32'd1;
      end
    end
  end

  assign stat_branches    = stat_br_r;
  assign stat_mispredicts = stat_mp_r;
`endif

  assign unused_s = ^{update_target, pc[1:0], pc[XLEN-1:IW+2],
                      update_pc[1:0], update_pc[XLEN-1:IW+2], pred_ctr_s[CTR_BITS-2:0]};

endmodule

// File: tb/tb_gshare_predictor.sv
// Directed self-checking bench for gshare_predictor (default and PRED_STATS_EN builds).
module tb_gshare_predictor;
  import riscv_pkg::*;

  logic         clk;
  logic         reset;
  logic         predict_en;
  logic [31:0]  pc;
  logic         btb_hit;
  logic [31:0]  btb_target;
  logic         btb_is_return;
  logic         ras_valid;
  logic [31:0]  ras_target;
  logic         update_en;
  logic [31:0]  update_pc;
  logic         update_is_branch;
  logic         update_taken;
  logic [31:0]  update_target;
  logic [7:0]   update_ghr;
  logic         update_mispredict;
  branch_pred_t prediction_out;
`ifdef PRED_STATS_EN
  logic [31:0]  stat_branches;
  logic [31:0]  stat_mispredicts;
`endif

  int checks = 0;
  int errors = 0;

  gshare_predictor dut (
    .clk               (clk),
    .reset             (reset),
    .predict_en        (predict_en),
    .pc                (pc),
    .btb_hit           (btb_hit),
    .btb_target        (btb_target),
    .btb_is_return     (btb_is_return),
    .ras_valid         (ras_valid),
    .ras_target        (ras_target),
    .update_en         (update_en),
    .update_pc         (update_pc),
    .update_is_branch  (update_is_branch),
    .update_taken      (update_taken),
    .update_target     (update_target),
    .update_ghr        (update_ghr),
    .update_mispredict (update_mispredict),
    .prediction_out    (prediction_out)
`ifdef PRED_STATS_EN
    ,
    .stat_branches     (stat_branches),
    .stat_mispredicts  (stat_mispredicts)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic branch_pred_t mk(input logic v, input logic t,
                                      input logic [31:0] tg, input logic [15:0] g);
    branch_pred_t p;
    p.valid  = v;
    p.taken  = t;
    p.target = tg;
    p.ghr    = g;
    return p;
  endfunction

  task automatic check(input string tag, input branch_pred_t exp);
    checks++;
    assert (prediction_out === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, prediction_out, exp);
    end
  endtask

  task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1; predict_en = 1'b0; pc = 32'h0; btb_hit = 1'b0; btb_target = 32'h0;
    btb_is_return = 1'b0; ras_valid = 1'b0; ras_target = 32'h0; update_en = 1'b0;
    update_pc = 32'h0; update_is_branch = 1'b0; update_taken = 1'b0;
    update_target = 32'h0; update_ghr = 8'h0; update_mispredict = 1'b0;

    #2;
    check("rst_idle", mk(1'b0, 1'b0, 32'h0, 16'h0));
`ifdef PRED_STATS_EN
    check32("rst_stat_br", stat_branches, 32'd0);
`endif
    predict_en = 1'b1; pc = 32'h100; btb_hit = 1'b1; btb_target = 32'h500;
    #1 check("rst_pred", mk(1'b1, 1'b0, 32'h104, 16'h0));

    // Train index of pc 0x100 / ghr 0 twice: 01 -> 10 -> 11.
    reset = 1'b0; predict_en = 1'b0;
    update_en = 1'b1; update_pc = 32'h100; update_is_branch = 1'b1;
    update_taken = 1'b1; update_ghr = 8'h00;
    tick();
    predict_en = 1'b1;
    #1 check("train1", mk(1'b1, 1'b1, 32'h500, 16'h0));
    predict_en = 1'b0;
    tick();
    update_en = 1'b0; predict_en = 1'b1;
    #1 check("train2", mk(1'b1, 1'b1, 32'h500, 16'h0));

    // Returns with a valid RAS are always taken; four of them fill GHR.
    btb_is_return = 1'b1; ras_valid = 1'b1; ras_target = 32'h2000;
    #1 check("ras_taken", mk(1'b1, 1'b1, 32'h2000, 16'h0));
    repeat (4) tick();
    check("ghr_0f", mk(1'b1, 1'b1, 32'h2000, 16'h000F));

    // Jump-target mispredict with predict_en still high: recovery wins.
    update_en = 1'b1; update_is_branch = 1'b0; update_mispredict = 1'b1;
    update_ghr = 8'h03; update_taken = 1'b0; update_pc = 32'h100;
    tick();
    update_en = 1'b0; update_mispredict = 1'b0;
    #1 check("recover_06", mk(1'b1, 1'b1, 32'h2000, 16'h0006));
    predict_en = 1'b0;

    // RAS invalid falls back to the counter (idx 0x46 -> 01, idx 0x40 -> 11).
    ras_valid = 1'b0; predict_en = 1'b1;
    #1 check("ras_fallback_nt", mk(1'b1, 1'b0, 32'h104, 16'h0006));
    pc = 32'h118;
    #1 check("ras_fallback_t", mk(1'b1, 1'b1, 32'h500, 16'h0006));
    predict_en = 1'b0; btb_is_return = 1'b0;

    // Same-cycle read and write of index 0x86: old value read, new next cycle.
    pc = 32'h200; predict_en = 1'b1;
    update_en = 1'b1; update_is_branch = 1'b1; update_taken = 1'b1;
    update_pc = 32'h200; update_ghr = 8'h06;
    #1 check("rw_same_old", mk(1'b1, 1'b0, 32'h204, 16'h0006));
    predict_en = 1'b0;
    tick();
    update_en = 1'b0; predict_en = 1'b1;
    #1 check("rw_same_new", mk(1'b1, 1'b1, 32'h500, 16'h0006));
    predict_en = 1'b0;

    // Five not-taken updates: 10 -> 01 -> 00 and stays; one taken gives 01.
    update_en = 1'b1; update_taken = 1'b0;
    repeat (5) tick();
    update_en = 1'b0; predict_en = 1'b1;
    #1 check("sat_low", mk(1'b1, 1'b0, 32'h204, 16'h0006));
    predict_en = 1'b0;
    update_en = 1'b1; update_taken = 1'b1;
    tick();
    update_en = 1'b0; predict_en = 1'b1;
    #1 check("sat_low_inc", mk(1'b1, 1'b0, 32'h204, 16'h0006));
    predict_en = 1'b0;

    // Index 0x40 at 11: taken keeps 11, then not-taken gives 10 (still taken).
    update_en = 1'b1; update_pc = 32'h100; update_ghr = 8'h00; update_taken = 1'b1;
    tick();
    update_taken = 1'b0;
    tick();
    update_en = 1'b0; pc = 32'h118; predict_en = 1'b1;
    #1 check("sat_high", mk(1'b1, 1'b1, 32'h500, 16'h0006));
`ifdef PRED_STATS_EN
    check32("stat_br", stat_branches, 32'd11);
    check32("stat_mp", stat_mispredicts, 32'd0);
`endif
    predict_en = 1'b0;

    // Mid-cycle async reset clears counters and GHR immediately.
    #3 reset = 1'b1; pc = 32'h100; predict_en = 1'b1;
    #1 check("mid_rst", mk(1'b1, 1'b0, 32'h104, 16'h0));
`ifdef PRED_STATS_EN
    check32("mid_rst_stat_br", stat_branches, 32'd0);
    check32("mid_rst_stat_mp", stat_mispredicts, 32'd0);
`endif
    predict_en = 1'b0;
    #1 check("mid_rst_idle", mk(1'b0, 1'b0, 32'h0, 16'h0));

    tick();
    reset = 1'b0; predict_en = 1'b1; btb_is_return = 1'b1; ras_valid = 1'b1;
    tick();
    check("post_rst_edge", mk(1'b1, 1'b1, 32'h2000, 16'h0001));
    predict_en = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
